bus_mux_arb: RTL and testbench
==============================

# bus_mux_arb

Parametrised successor to the datapath bus multiplexer. It takes NUM_SRC source words of WIDTH bits, each with a one-hot-intended output-enable, and drives a single bus. It does this with:
- a fixed-priority select (lowest index wins);
- an optional output register;
- an optional hold-last-value mode;
- multiple-driver conflict detection with a sticky error;
- a saturating transfer counter for debug.

It sits between the register file, special registers (HI, LO, Z, PC, MDR, in-port, constant) and all bus consumers.

## Interface
Parameters:
- WIDTH, 32, bus word width.
- NUM_SRC, 24, number of bus sources (2..64).
- REG_OUT, 1, 1 = bus_out registered (1-cycle latency); 0 = combinational bus_out.
- HOLD_LAST, 0, 1 = bus keeps last driven value when no enable is active; 0 = bus reads 0.
- CNT_W, 16, transfer counter width.
- SEL_W is derived, not overridable: clog2(NUM_SRC+1).

Ports:
- clock, in, 1, rising-edge clock.
- clear_n, in, 1, asynchronous active-low reset.
- src_data, in, NUM_SRC*WIDTH, flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_out, in, NUM_SRC, per-source output enable; bit i enables source i.
- clr_stats, in, 1, synchronous clear of err_sticky, err_idx and xfer_count.
- bus_out, out, WIDTH, bus value.
- bus_valid, out, 1, a source drove bus_out this cycle (registered in step with bus_out when REG_OUT=1).
- sel_idx, out, SEL_W, index of the winning source; all-ones when none. Always combinational.
- conflict, out, 1, more than one src_out bit is set this cycle. Combinational.
- err_sticky, out, 1, a conflict has occurred since the last reset or clr_stats.
- err_idx, out, SEL_W, the sel_idx value in the first conflicting cycle.
- xfer_count, out, CNT_W, number of cycles with at least one enable since the last clear; saturating.

## Operation
- Priority select:
  - sel_idx = lowest i with src_out[i]=1.
  - If src_out == 0, sel_idx = {SEL_W{1'b1}} and the default path applies.
- Raw bus value (internal), by case:
  - If any enable is set: src_data word[sel_idx].
  - If none and HOLD_LAST=0: 0.
  - If none and HOLD_LAST=1: the hold register.
- Hold register: loads the selected word on every edge where any src_out bit is set; otherwise keeps its value.
- REG_OUT=1: bus_out and bus_valid are flops loaded each edge from the raw value and from (src_out != 0).
- REG_OUT=0: bus_out = raw value and bus_valid = (src_out != 0), both combinational.
- conflict = src_out has two or more bits set. The winner is still driven; conflict does not change the bus value.
- err_sticky and err_idx:
  - When a conflict occurs and err_sticky=0: set err_sticky and latch err_idx = sel_idx.
  - Further conflicts do not overwrite err_idx.
  - clr_stats clears both.
  - If clr_stats and a conflict occur in the same cycle, the set wins: err_sticky=1 and err_idx = current sel_idx.
- xfer_count:
  - Increments by 1 on each edge where src_out != 0.
  - Holds at 2^CNT_W-1 and never wraps.
  - If clr_stats and a transfer occur in the same cycle, the clear wins: result is 0.
- Width rules:
  - No arithmetic on data.
  - Index compare is unsigned.
  - SEL_W must cover NUM_SRC, so the all-ones code is never a valid source index.

## Timing
- Reset (clear_n=0, asynchronous, any time, including mid-transfer) forces:
  - bus_out=0, bus_valid=0, hold register=0;
  - err_sticky=0, err_idx=0, xfer_count=0.
- sel_idx and conflict follow the inputs combinationally, even while in reset.
- REG_OUT=1:
  - An enable asserted before edge N appears on bus_out/bus_valid after edge N, giving 1-cycle latency.
  - Back-to-back enables of different sources give back-to-back bus words with no bubble.
- REG_OUT=0: bus_out settles in the same cycle as src_out; the hold register still updates on the edge.
- err_sticky, err_idx and xfer_count update on the edge following the causing cycle.
- After reset deassertion, the first edge is a normal operating edge.

## Test plan
- Single enables, defaults (REG_OUT=1, HOLD_LAST=0, NUM_SRC=24, WIDTH=32):
  - Stimulus: src_out=1<<5 with word5=32'hDEADBEEF, then src_out=0.
  - Required: sel_idx=5 immediately; bus_out=DEADBEEF and bus_valid=1 after one edge; then bus_out=0, bus_valid=0, sel_idx=5'h1F, xfer_count=1.
- Hold mode (HOLD_LAST=1):
  - Stimulus: drive source 20 with 32'h00000123 for one cycle, then idle 3 cycles.
  - Required: bus_out stays 00000123 with bus_valid=0 during the idle cycles; reset clears bus_out to 0.
- Conflict:
  - Stimulus: src_out bits 3 and 7 set together, then bit 1 and bit 2 together.
  - Required: conflict=1 in both cycles; bus shows word3, then word1; err_sticky=1; err_idx=3 (not overwritten).
  - Then clr_stats alone: err_sticky=0, err_idx=0, xfer_count=0.
- Saturation (CNT_W=3):
  - Stimulus: 10 consecutive enable cycles.
  - Required: xfer_count reads 1..7 and then holds at 7.
  - clr_stats together with an enable gives xfer_count=0.
- Async reset mid-stream (REG_OUT=1):
  - Stimulus: drop clear_n between edges while bus_out=DEADBEEF and err_sticky=1.
  - Required: all registered outputs go to 0 immediately without waiting for an edge; the first edge after release loads the current selection.
- Combinational variant (REG_OUT=0):
  - Stimulus: enable source 23 with 32'hFFFF0000.
  - Required: bus_out equals FFFF0000 in the same cycle, bus_valid=1, xfer_count increments on the next edge.

Source files
------------

// File: rtl/bus_mux_arb_if.sv
// Bus-source side and consumer side of the priority bus multiplexer, bundled.
// The master drives sources and clr_stats; the slave (the mux) returns the bus and status.
interface bus_mux_arb_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 24,
   parameter int CNT_W   = 16
);
   localparam int SEL_W = $clog2(NUM_SRC + 1);

   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]       src_out;
   logic                     clr_stats;
   logic [WIDTH-1:0]         bus_out;
   logic                     bus_valid;
   logic [SEL_W-1:0]         sel_idx;
   logic                     conflict;
   logic                     err_sticky;
   logic [SEL_W-1:0]         err_idx;
   logic [CNT_W-1:0]         xfer_count;

   modport master (
      output src_data, src_out, clr_stats,
      input  bus_out, bus_valid, sel_idx, conflict, err_sticky, err_idx, xfer_count
   );

   modport slave (
      input  src_data, src_out, clr_stats,
      output bus_out, bus_valid, sel_idx, conflict, err_sticky, err_idx, xfer_count
   );
endinterface

// File: rtl/bus_mux_arb.sv
// Fixed-priority (lowest index wins) bus multiplexer with optional output register,
// optional hold-last-value, sticky multi-driver error capture and a saturating transfer counter.
module bus_mux_arb #(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC   = 24,
   parameter int REG_OUT   = 1,
   parameter int HOLD_LAST = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clock,
   input  logic             clear_n,
   bus_mux_arb_if.slave     mux
);
   localparam int SEL_W = $clog2(NUM_SRC + 1);

   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] raw;
   logic             any_en;
   logic             multi_en;

   logic [WIDTH-1:0] hold_q;
   logic             err_q;
   logic [SEL_W-1:0] err_idx_q;
   logic [CNT_W-1:0] xfer_q;

   // Scanning downward leaves the lowest set index as the final assignment.
   always_comb begin
      sel  = '1;
      word = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (mux.src_out[i]) begin
            sel  = SEL_W'(i);
            word = mux.src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign any_en   = |mux.src_out;
   assign multi_en = (mux.src_out & (mux.src_out - NUM_SRC'(1))) != '0;
   assign raw      = any_en ? word : ((HOLD_LAST != 0) ? hold_q : '0);

   assign mux.sel_idx  = sel;
   assign mux.conflict = multi_en;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         hold_q <= '0;
      end else if (any_en) begin
         hold_q <= word;
      end
   end

   // A conflict coinciding with clr_stats re-arms the capture with the current winner.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         err_q     <= 1'b0;
         err_idx_q <= '0;
      end else if (multi_en && (!err_q || mux.clr_stats)) begin
         err_q     <= 1'b1;
         err_idx_q <= sel;
      end else if (mux.clr_stats) begin
         err_q     <= 1'b0;
         err_idx_q <= '0;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         xfer_q <= '0;
      end else if (mux.clr_stats) begin
         xfer_q <= '0;
      end else if (any_en && (xfer_q != '1)) begin
         xfer_q <= xfer_q + CNT_W'(1);
      end
   end

   assign mux.err_sticky = err_q;
   assign mux.err_idx    = err_idx_q;
   assign mux.xfer_count = xfer_q;

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [WIDTH-1:0] out_q;
         logic             valid_q;

         always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
               out_q   <= '0;
               valid_q <= 1'b0;
            end else begin
               out_q   <= raw;
               valid_q <= any_en;
            end
         end

         assign mux.bus_out   = out_q;
         assign mux.bus_valid = valid_q;
      end else begin : g_comb_out
         assign mux.bus_out   = raw;
         assign mux.bus_valid = any_en;
      end
   endgenerate
endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed bench for bus_mux_arb: default, hold-last, narrow-counter and combinational variants.
module tb_bus_mux_arb;
   logic clock = 1'b0;
   logic clear_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   bus_mux_arb_if #(.WIDTH(32), .NUM_SRC(24), .CNT_W(16)) if_def  ();
   bus_mux_arb_if #(.WIDTH(32), .NUM_SRC(24), .CNT_W(16)) if_hold ();
   bus_mux_arb_if #(.WIDTH(32), .NUM_SRC(24), .CNT_W(3))  if_sat  ();
   bus_mux_arb_if #(.WIDTH(32), .NUM_SRC(24), .CNT_W(16)) if_comb ();

   bus_mux_arb #(.WIDTH(32), .NUM_SRC(24), .REG_OUT(1), .HOLD_LAST(0), .CNT_W(16))
      u_def  (.clock(clock), .clear_n(clear_n), .mux(if_def));
   bus_mux_arb #(.WIDTH(32), .NUM_SRC(24), .REG_OUT(1), .HOLD_LAST(1), .CNT_W(16))
      u_hold (.clock(clock), .clear_n(clear_n), .mux(if_hold));
   bus_mux_arb #(.WIDTH(32), .NUM_SRC(24), .REG_OUT(1), .HOLD_LAST(0), .CNT_W(3))
      u_sat  (.clock(clock), .clear_n(clear_n), .mux(if_sat));
   bus_mux_arb #(.WIDTH(32), .NUM_SRC(24), .REG_OUT(0), .HOLD_LAST(0), .CNT_W(16))
      u_comb (.clock(clock), .clear_n(clear_n), .mux(if_comb));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      if_def.src_data  = '0;  if_def.src_out  = '0;  if_def.clr_stats  = 1'b0;
      if_hold.src_data = '0;  if_hold.src_out = '0;  if_hold.clr_stats = 1'b0;
      if_sat.src_data  = '0;  if_sat.src_out  = '0;  if_sat.clr_stats  = 1'b0;
      if_comb.src_data = '0;  if_comb.src_out = '0;  if_comb.clr_stats = 1'b0;

      #1;
      chk("rst_bus",   if_def.bus_out, 0);
      chk("rst_valid", if_def.bus_valid, 0);
      chk("rst_xfer",  if_def.xfer_count, 0);
      chk("rst_err",   if_def.err_sticky, 0);
      chk("rst_sel",   if_def.sel_idx, 5'h1F);
      tick();
      tick();
      clear_n = 1'b1;

      // single enable
      if_def.src_data[5*32 +: 32] = 32'hDEADBEEF;
      if_def.src_out = 24'(1) << 5;
      #1;
      chk("single_sel_comb", if_def.sel_idx, 5);
      chk("single_noconf",   if_def.conflict, 0);
      chk("single_bus_pre",  if_def.bus_out, 0);
      tick();
      chk("single_bus",   if_def.bus_out, 32'hDEADBEEF);
      chk("single_valid", if_def.bus_valid, 1);
      chk("single_xfer",  if_def.xfer_count, 1);
      if_def.src_out = '0;
      #1;
      chk("idle_sel", if_def.sel_idx, 5'h1F);
      tick();
      chk("idle_bus",   if_def.bus_out, 0);
      chk("idle_valid", if_def.bus_valid, 0);
      chk("idle_xfer",  if_def.xfer_count, 1);

      // back-to-back sources, no bubble
      if_def.src_data[0*32 +: 32]  = 32'h11111111;
      if_def.src_data[23*32 +: 32] = 32'h23232323;
      if_def.src_out = 24'(1);
      tick();
      chk("b2b_first", if_def.bus_out, 32'h11111111);
      if_def.src_out = 24'(1) << 23;
      #1;
      chk("b2b_sel23", if_def.sel_idx, 23);
      tick();
      chk("b2b_second", if_def.bus_out, 32'h23232323);
      chk("b2b_valid",  if_def.bus_valid, 1);
      if_def.src_out = '0;
      tick();
      chk("b2b_xfer", if_def.xfer_count, 3);

      // conflicts
      if_def.src_data[1*32 +: 32] = 32'h11110001;
      if_def.src_data[2*32 +: 32] = 32'h22222222;
      if_def.src_data[3*32 +: 32] = 32'h33333333;
      if_def.src_data[7*32 +: 32] = 32'h77777777;
      if_def.src_out = (24'(1) << 3) | (24'(1) << 7);
      #1;
      chk("conf1_flag", if_def.conflict, 1);
      chk("conf1_sel",  if_def.sel_idx, 3);
      tick();
      chk("conf1_bus",    if_def.bus_out, 32'h33333333);
      chk("conf1_sticky", if_def.err_sticky, 1);
      chk("conf1_idx",    if_def.err_idx, 3);
      if_def.src_out = 24'h000006;
      #1;
      chk("conf2_flag", if_def.conflict, 1);
      tick();
      chk("conf2_bus", if_def.bus_out, 32'h11110001);
      chk("conf2_idx", if_def.err_idx, 3);
      chk("conf2_xfer", if_def.xfer_count, 5);
      if_def.src_out   = '0;
      if_def.clr_stats = 1'b1;
      tick();
      chk("clr_sticky", if_def.err_sticky, 0);
      chk("clr_idx",    if_def.err_idx, 0);
      chk("clr_xfer",   if_def.xfer_count, 0);

      // clr_stats together with a conflict: set wins for error, clear wins for counter
      if_def.src_out = (24'(1) << 4) | (24'(1) << 9);
      tick();
      chk("clrconf_sticky", if_def.err_sticky, 1);
      chk("clrconf_idx",    if_def.err_idx, 4);
      chk("clrconf_xfer",   if_def.xfer_count, 0);
      if_def.clr_stats = 1'b0;

      // async reset between edges
      if_def.src_out = 24'(1) << 5;
      tick();
      chk("pre_rst_bus",    if_def.bus_out, 32'hDEADBEEF);
      chk("pre_rst_sticky", if_def.err_sticky, 1);
      #2;
      clear_n = 1'b0;
      #1;
      chk("arst_bus",    if_def.bus_out, 0);
      chk("arst_valid",  if_def.bus_valid, 0);
      chk("arst_sticky", if_def.err_sticky, 0);
      chk("arst_idx",    if_def.err_idx, 0);
      chk("arst_xfer",   if_def.xfer_count, 0);
      chk("arst_sel",    if_def.sel_idx, 5);
      clear_n = 1'b1;
      tick();
      chk("post_rst_bus",   if_def.bus_out, 32'hDEADBEEF);
      chk("post_rst_valid", if_def.bus_valid, 1);
      chk("post_rst_xfer",  if_def.xfer_count, 1);
      if_def.src_out = '0;

      // hold-last mode
      if_hold.src_data[20*32 +: 32] = 32'h00000123;
      if_hold.src_out = 24'(1) << 20;
      tick();
      chk("hold_load", if_hold.bus_out, 32'h00000123);
      if_hold.src_out = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("hold_idle%0d_bus", k),   if_hold.bus_out, 32'h00000123);
         chk($sformatf("hold_idle%0d_valid", k), if_hold.bus_valid, 0);
      end
      #2;
      clear_n = 1'b0;
      #1;
      chk("hold_rst_bus", if_hold.bus_out, 0);
      clear_n = 1'b1;
      tick();
      chk("hold_after_rst", if_hold.bus_out, 0);

      // saturation with a 3-bit counter
      if_sat.src_out = 24'(1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("sat_%0d", k), if_sat.xfer_count, (k > 7) ? 7 : k);
      end
      if_sat.clr_stats = 1'b1;
      tick();
      chk("sat_clr_with_en", if_sat.xfer_count, 0);
      if_sat.clr_stats = 1'b0;
      tick();
      chk("sat_restart", if_sat.xfer_count, 1);
      if_sat.src_out = '0;

      // combinational variant
      if_comb.src_data[23*32 +: 32] = 32'hFFFF0000;
      if_comb.src_out = 24'(1) << 23;
      #1;
      chk("comb_bus",   if_comb.bus_out, 32'hFFFF0000);
      chk("comb_valid", if_comb.bus_valid, 1);
      chk("comb_xfer0", if_comb.xfer_count, 0);
      tick();
      chk("comb_xfer1", if_comb.xfer_count, 1);
      if_comb.src_out = '0;
      #1;
      chk("comb_idle_bus",   if_comb.bus_out, 0);
      chk("comb_idle_valid", if_comb.bus_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
